mux_nway_reg: RTL and testbench
===============================

# mux_nway_reg

Parametrised, registered N-way word multiplexer with a valid/ready handshake on every channel and the output. It has two modes: select-driven (an external `Sel` picks the channel) and round-robin arbitration among valid channels. It generalises the datapath's 2:1 word muxes for pipelined paths such as writeback/forwarding source selection and shared-port arbitration. The output is a single-entry register, so the block adds one pipeline stage.

## Interface
Parameters:
- `WIDTH`, 32: data word width in bits (≥1).
- `NUM_IN`, 4: number of input channels (≥2).
- `MODE`, 0: 0 = select-driven, 1 = round-robin arbitration.
- `SEL_W`, `$clog2(NUM_IN)`: select/channel-index width (derived; do not override).

Ports:
- `Clk`, in, 1: single clock, all state changes on rising edge.
- `Reset`, in, 1: synchronous, active-low reset (sampled on `Clk` rising edge; 0 = reset).
- `InData`, in, NUM_IN*WIDTH: channel i occupies bits [i*WIDTH +: WIDTH].
- `InValid`, in, NUM_IN: channel i presents a word.
- `InReady`, out, NUM_IN: channel i word accepted this cycle when `InValid[i] & InReady[i]`.
- `Sel`, in, SEL_W: channel select (MODE 0 only; ignored in MODE 1).
- `OutData`, out, WIDTH: registered output word.
- `OutChan`, out, SEL_W: index of channel that supplied `OutData`.
- `OutValid`, out, 1: output register holds a word.
- `OutReady`, in, 1: downstream accepts word when `OutValid & OutReady`.

## Operation
- Output register state: EMPTY (`OutValid`=0) / FULL (`OutValid`=1).
- `can_load` = `~OutValid | OutReady`, meaning the register is empty or drains this cycle.
- Grant `g` (one-hot, at most one bit) is computed combinationally each cycle:
  - MODE 0: `g[Sel]` = `InValid[Sel]`. If `Sel` ≥ NUM_IN (non-power-of-2 NUM_IN), `g` = 0.
  - MODE 1: pick the first valid channel scanning `last+1, last+2, …` modulo NUM_IN, where `last` is the registered index of the most recently accepted channel. `g` = 0 if no `InValid`.
- `InReady[i]` = `g[i] & can_load`. All other channels see `InReady`=0 and must hold their data (AXI-style; the block never drops a presented word).
- On an edge with `|g & can_load`, the block loads `OutData` ← the granted channel's word, `OutChan` ← its index, and `OutValid` ← 1. In MODE 1 it also sets `last` ← the granted index.
- On an edge with `OutValid & OutReady` and no new grant, `OutValid` ← 0. `OutData`/`OutChan` hold their last value.
- Simultaneous drain and load: the new word replaces the old one in the same edge, and `OutValid` stays 1. This gives full throughput.
- FULL and `OutReady`=0: `OutData`, `OutChan` and `OutValid` hold stable, and all `InReady` = 0.
- `last` updates only on acceptance, never on idle cycles.
- Reset (`Reset`=0 at edge, including mid-transfer):
  - `OutValid`=0, `OutData`=0, `OutChan`=0.
  - `last`=NUM_IN-1, so channel 0 has first priority after reset.
  - A word held in the register is discarded.
  - `InReady` is forced to 0 during any cycle with `Reset`=0.

## Timing
- Latency: a word accepted at edge k appears on `OutData` with `OutValid`=1 after edge k. That is one cycle.
- Throughput: one word per cycle when `OutReady`=1 continuously.
- `InReady` depends combinationally on `InValid`, `Sel`, `OutValid`, `OutReady` and `last`. There is no combinational path from `InData` to any output.
- `OutData`, `OutChan` and `OutValid` are driven directly from flops.
- MODE 1 fairness: with all NUM_IN channels continuously valid and `OutReady`=1, grants cycle 0,1,…,NUM_IN-1,0,… with no channel skipped. Worst-case wait for a valid channel is NUM_IN-1 accepted words.
- `Sel` may change any cycle. It affects only the grant of that cycle and never disturbs a held output word.

## Test plan
- Reset and legacy-equivalent selection (WIDTH=4, NUM_IN=2, MODE 0): set `InData`={B:0x5, A:0xA}, both valid, `OutReady`=1. Drive `Reset`=0 for 2 cycles, then 1.
  - During reset: `OutValid`=0, `OutData`=0.
  - `Sel`=0 gives `OutData`=0xA, `OutChan`=0 one cycle later.
  - `Sel`=1 gives 0x5, `OutChan`=1.
- Backpressure (MODE 0, WIDTH=32): load 0xDEADBEEF, then hold `OutReady`=0 for 5 cycles while changing `Sel` and `InData`.
  - `OutData` must stay 0xDEADBEEF and `OutValid`=1.
  - All `InReady`=0.
  - The first cycle with `OutReady`=1 accepts the next word.
- Full throughput: stream 8 words 0x00…0x07 on channel 2 with `OutReady`=1.
  - `InReady[2]`=1 every cycle.
  - `OutData` sequence is 0x00…0x07 on consecutive cycles, starting one cycle after the first accept.
- Round-robin (MODE 1, NUM_IN=4): all channels valid with data=index, `OutReady`=1.
  - `OutChan` sequence after reset is 0,1,2,3,0,1.
  - Drop `InValid[1]`: the sequence skips 1 (0,2,3,0,…).
- Out-of-range and empty cases:
  - NUM_IN=3, MODE 0, `Sel`=3: no `InReady`, and `OutValid` falls to 0 after the pending word drains.
  - MODE 1 with `InValid`=0: no load, and `last` is unchanged.
- Reset mid-operation: assert `Reset`=0 while FULL with `OutReady`=0.
  - Next edge: `OutValid`=0, `OutData`=0.
  - After release, MODE 1 grants channel 0 first.

Source files
------------

// File: rtl/mux_nway_reg.sv
// Registered N-way word multiplexer with valid/ready handshakes.
// MODE 0 picks the channel named by Sel; MODE 1 arbitrates round-robin
// among valid channels. The output is a single-entry register, so the
// block adds exactly one pipeline stage and sustains one word per cycle.
module mux_nway_reg #(
    parameter int WIDTH  = 32,
    parameter int NUM_IN = 4,
    parameter int MODE   = 0,
    parameter int SEL_W  = $clog2(NUM_IN)
) (
    input  logic                    Clk,
    input  logic                    Reset,
    input  logic [NUM_IN*WIDTH-1:0] InData,
    input  logic [NUM_IN-1:0]       InValid,
    output logic [NUM_IN-1:0]       InReady,
    input  logic [SEL_W-1:0]        Sel,
    output logic [WIDTH-1:0]        OutData,
    output logic [SEL_W-1:0]        OutChan,
    output logic                    OutValid,
    input  logic                    OutReady
);

    logic [WIDTH-1:0]  out_data_q,  out_data_d;
    logic [SEL_W-1:0]  out_chan_q,  out_chan_d;
    logic              out_valid_q, out_valid_d;
    logic [SEL_W-1:0]  last_q,      last_d;

    logic [NUM_IN-1:0] grant_oh;
    logic [SEL_W-1:0]  grant_idx;
    logic              grant_vld;
    logic              can_load;

    // The register can take a new word when it is empty or drains this cycle.
    assign can_load  = ~out_valid_q | OutReady;
    assign grant_vld = |grant_oh;

    // Grant: one-hot choice of the channel that may load this cycle.
    always_comb begin
        // NOTE: every signal written here gets a default first, so no path
        // through the block leaves it unassigned and no latch is inferred.
        grant_oh  = '0;
        grant_idx = '0;
        if (MODE == 0) begin
            // An out-of-range Sel matches no channel, so nothing is granted.
            for (int i = 0; i < NUM_IN; i++) begin
                if (Sel == SEL_W'(i) && InValid[i]) begin
                    grant_oh[i] = 1'b1;
                    grant_idx   = SEL_W'(i);
                end
            end
        end else begin
            // Scan last+1 .. NUM_IN-1 first, then wrap to 0 .. last.
            for (int i = 0; i < NUM_IN; i++) begin
                if (!(|grant_oh) && InValid[i] && SEL_W'(i) > last_q) begin
                    grant_oh[i] = 1'b1;
                    grant_idx   = SEL_W'(i);
                end
            end
            for (int i = 0; i < NUM_IN; i++) begin
                if (!(|grant_oh) && InValid[i] && SEL_W'(i) <= last_q) begin
                    grant_oh[i] = 1'b1;
                    grant_idx   = SEL_W'(i);
                end
            end
        end
    end

    // Handshake back to the channels; nobody is accepted while in reset.
    always_comb begin
        InReady = '0;
        if (Reset) begin
            InReady = grant_oh & {NUM_IN{can_load}};
        end
    end

    // Next state of the output register and the round-robin pointer.
    always_comb begin
        out_data_d  = out_data_q;
        out_chan_d  = out_chan_q;
        out_valid_d = out_valid_q;
        last_d      = last_q;
        if (grant_vld && can_load) begin
            // A load in the same edge as a drain simply replaces the word.
            out_data_d = '0;
            for (int i = 0; i < NUM_IN; i++) begin
                if (grant_oh[i]) begin
                    out_data_d = InData[i*WIDTH +: WIDTH];
                end
            end
            out_chan_d  = grant_idx;
            out_valid_d = 1'b1;
            if (MODE == 1) begin
                last_d = grant_idx;
            end
        end else if (OutReady) begin
            out_valid_d = 1'b0;
        end
    end

    // State registers with synchronous active-low reset.
    always_ff @(posedge Clk) begin
        // NOTE: sequential state uses non-blocking assignments so every flop
        // samples its pre-edge inputs regardless of statement order.
        if (!Reset) begin
            out_data_q  <= '0;
            out_chan_q  <= '0;
            out_valid_q <= 1'b0;
            last_q      <= SEL_W'(NUM_IN - 1);
        end else begin
            out_data_q  <= out_data_d;
            out_chan_q  <= out_chan_d;
            out_valid_q <= out_valid_d;
            last_q      <= last_d;
        end
    end

    assign OutData  = out_data_q;
    assign OutChan  = out_chan_q;
    assign OutValid = out_valid_q;

endmodule

// File: tb/tb_mux_nway_reg.sv
// Self-checking bench for mux_nway_reg. Three instances share one clock
// and reset: A (4-bit, 2 ch, select), B (32-bit, 3 ch, select) and
// C (8-bit, 4 ch, round-robin). A behavioural model tracks each one.
module tb_mux_nway_reg;

    localparam int ND = 3;
    localparam int NIN    [ND] = '{2, 3, 4};
    localparam int MODE_P [ND] = '{0, 0, 1};
    localparam int WID    [ND] = '{4, 32, 8};

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n;
    logic [31:0] in_data   [ND][4];
    logic [3:0]  in_valid  [ND];
    int          sel       [ND];
    logic        out_ready [ND];

    // Behavioural model state
    logic        m_valid [ND];
    logic [31:0] m_data  [ND];
    int          m_chan  [ND];
    int          m_last  [ND];

    int checks = 0;
    int fails  = 0;

    // DUT A
    logic [7:0] a_in_data;
    logic [1:0] a_in_valid, a_in_ready;
    logic       a_sel, a_out_chan, a_out_valid;
    logic [3:0] a_out_data;
    assign a_in_data  = {in_data[0][1][3:0], in_data[0][0][3:0]};
    assign a_in_valid = in_valid[0][1:0];
    assign a_sel      = 1'(sel[0]);

    // DUT B
    logic [95:0] b_in_data;
    logic [2:0]  b_in_valid, b_in_ready;
    logic [1:0]  b_sel, b_out_chan;
    logic [31:0] b_out_data;
    logic        b_out_valid;
    assign b_in_data  = {in_data[1][2], in_data[1][1], in_data[1][0]};
    assign b_in_valid = in_valid[1][2:0];
    assign b_sel      = 2'(sel[1]);

    // DUT C
    logic [31:0] c_in_data;
    logic [3:0]  c_in_valid, c_in_ready;
    logic [1:0]  c_sel, c_out_chan;
    logic [7:0]  c_out_data;
    logic        c_out_valid;
    assign c_in_data  = {in_data[2][3][7:0], in_data[2][2][7:0], in_data[2][1][7:0], in_data[2][0][7:0]};
    assign c_in_valid = in_valid[2];
    assign c_sel      = 2'(sel[2]);

    mux_nway_reg #(.WIDTH(4), .NUM_IN(2), .MODE(0)) u_a (
        .Clk(clk), .Reset(rst_n), .InData(a_in_data), .InValid(a_in_valid),
        .InReady(a_in_ready), .Sel(a_sel), .OutData(a_out_data),
        .OutChan(a_out_chan), .OutValid(a_out_valid), .OutReady(out_ready[0])
    );

    mux_nway_reg #(.WIDTH(32), .NUM_IN(3), .MODE(0)) u_b (
        .Clk(clk), .Reset(rst_n), .InData(b_in_data), .InValid(b_in_valid),
        .InReady(b_in_ready), .Sel(b_sel), .OutData(b_out_data),
        .OutChan(b_out_chan), .OutValid(b_out_valid), .OutReady(out_ready[1])
    );

    mux_nway_reg #(.WIDTH(8), .NUM_IN(4), .MODE(1)) u_c (
        .Clk(clk), .Reset(rst_n), .InData(c_in_data), .InValid(c_in_valid),
        .InReady(c_in_ready), .Sel(c_sel), .OutData(c_out_data),
        .OutChan(c_out_chan), .OutValid(c_out_valid), .OutReady(out_ready[2])
    );

    // ---------------- DUT observation ----------------
    function automatic logic [3:0] act_ready(int d);
        case (d)
            0:       return {2'b00, a_in_ready};
            1:       return {1'b0, b_in_ready};
            default: return c_in_ready;
        endcase
    endfunction

    function automatic logic act_valid(int d);
        case (d)
            0:       return a_out_valid;
            1:       return b_out_valid;
            default: return c_out_valid;
        endcase
    endfunction

    function automatic logic [31:0] act_data(int d);
        case (d)
            0:       return {28'd0, a_out_data};
            1:       return b_out_data;
            default: return {24'd0, c_out_data};
        endcase
    endfunction

    function automatic int act_chan(int d);
        case (d)
            0:       return int'(a_out_chan);
            1:       return int'(b_out_chan);
            default: return int'(c_out_chan);
        endcase
    endfunction

    // ---------------- Reference model ----------------
    function automatic logic [31:0] wmask(int d);
        if (WID[d] >= 32) return 32'hFFFF_FFFF;
        return (32'd1 << WID[d]) - 32'd1;
    endfunction

    // Granted channel index, or -1 when nothing is granted.
    function automatic int m_grant(int d);
        if (MODE_P[d] == 0) begin
            if (sel[d] < NIN[d] && in_valid[d][sel[d]]) return sel[d];
            return -1;
        end
        for (int k = 1; k <= NIN[d]; k++) begin
            int c = (m_last[d] + k) % NIN[d];
            if (in_valid[d][c]) return c;
        end
        return -1;
    endfunction

    function automatic logic [3:0] m_ready(int d);
        int g = m_grant(d);
        if (!rst_n || g < 0) return 4'b0000;
        if (m_valid[d] && !out_ready[d]) return 4'b0000;
        return 4'b0001 << g;
    endfunction

    // Advance one clock edge, updating the model from pre-edge inputs.
    task automatic step();
        int   g  [ND];
        logic cl [ND];
        logic r;
        r = rst_n;
        for (int d = 0; d < ND; d++) begin
            g[d]  = m_grant(d);
            cl[d] = !m_valid[d] || out_ready[d];
        end
        @(posedge clk);
        for (int d = 0; d < ND; d++) begin
            if (!r) begin
                m_valid[d] = 1'b0;
                m_data[d]  = '0;
                m_chan[d]  = 0;
                m_last[d]  = NIN[d] - 1;
            end else if (g[d] >= 0 && cl[d]) begin
                m_valid[d] = 1'b1;
                m_data[d]  = in_data[d][g[d]] & wmask(d);
                m_chan[d]  = g[d];
                if (MODE_P[d] == 1) m_last[d] = g[d];
            end else if (m_valid[d] && out_ready[d]) begin
                m_valid[d] = 1'b0;
            end
        end
        #1;
    endtask

    // ---------------- Scenarios ----------------
    task automatic test_reset();
        rst_n = 1'b0;
        in_data[0][0] = 32'hA;
        in_data[0][1] = 32'h5;
        in_valid[0] = 4'b0011;
        in_valid[1] = 4'b0111;
        in_valid[2] = 4'b1111;
        sel[0] = 0;
        for (int d = 0; d < ND; d++) out_ready[d] = 1'b1;
        repeat (2) begin
            #1;
            for (int d = 0; d < ND; d++) begin
                checks++;
                if (act_ready(d) !== 4'b0000) begin
                    fails++;
                    $display("FAIL reset_ready dut%0d: got %b want 0000", d, act_ready(d));
                end
            end
            step();
            for (int d = 0; d < ND; d++) begin
                checks++;
                if (act_valid(d) !== 1'b0 || act_data(d) !== 32'd0 || act_chan(d) !== 0) begin
                    fails++;
                    $display("FAIL reset_out dut%0d: got v=%b d=%h c=%0d want v=0 d=0 c=0",
                             d, act_valid(d), act_data(d), act_chan(d));
                end
            end
        end
        in_valid[1] = 4'b0000;
        in_valid[2] = 4'b0000;
    endtask

    task automatic test_legacy_select();
        int exp_d [2] = '{'hA, 'h5};
        rst_n = 1'b1;
        for (int s = 0; s < 2; s++) begin
            sel[0] = s;
            #1;
            checks++;
            if (a_in_ready !== (2'b01 << s)) begin
                fails++;
                $display("FAIL legacy_ready sel=%0d: got %b want %b", s, a_in_ready, 2'b01 << s);
            end
            step();
            checks++;
            if (a_out_valid !== 1'b1 || a_out_data !== 4'(exp_d[s]) || a_out_chan !== 1'(s)) begin
                fails++;
                $display("FAIL legacy_out sel=%0d: got v=%b d=%h c=%0d want v=1 d=%h c=%0d",
                         s, a_out_valid, a_out_data, a_out_chan, exp_d[s], s);
            end
        end
    endtask

    task automatic test_backpressure();
        in_valid[1] = 4'b0111;
        in_data[1][1] = 32'hDEAD_BEEF;
        sel[1] = 1;
        out_ready[1] = 1'b1;
        #1;
        step();
        checks++;
        if (b_out_data !== 32'hDEAD_BEEF || b_out_valid !== 1'b1 || b_out_chan !== 2'd1) begin
            fails++;
            $display("FAIL bp_load: got v=%b d=%h c=%0d want v=1 d=deadbeef c=1",
                     b_out_valid, b_out_data, b_out_chan);
        end
        out_ready[1] = 1'b0;
        repeat (5) begin
            sel[1] = $urandom_range(0, 3);
            for (int i = 0; i < 3; i++) in_data[1][i] = $urandom;
            #1;
            checks++;
            if (b_in_ready !== 3'b000) begin
                fails++;
                $display("FAIL bp_ready: got %b want 000", b_in_ready);
            end
            step();
            checks++;
            if (b_out_data !== 32'hDEAD_BEEF || b_out_valid !== 1'b1 || b_out_chan !== 2'd1) begin
                fails++;
                $display("FAIL bp_hold: got v=%b d=%h c=%0d want v=1 d=deadbeef c=1",
                         b_out_valid, b_out_data, b_out_chan);
            end
        end
        out_ready[1] = 1'b1;
        sel[1] = 2;
        in_data[1][2] = 32'h1234_5678;
        #1;
        checks++;
        if (b_in_ready !== 3'b100) begin
            fails++;
            $display("FAIL bp_release_ready: got %b want 100", b_in_ready);
        end
        step();
        checks++;
        if (b_out_data !== 32'h1234_5678 || b_out_chan !== 2'd2) begin
            fails++;
            $display("FAIL bp_release_out: got d=%h c=%0d want d=12345678 c=2", b_out_data, b_out_chan);
        end
    endtask

    task automatic test_throughput();
        sel[1] = 2;
        in_valid[1] = 4'b0100;
        out_ready[1] = 1'b1;
        for (int i = 0; i < 8; i++) begin
            in_data[1][2] = 32'(i);
            #1;
            checks++;
            if (b_in_ready[2] !== 1'b1) begin
                fails++;
                $display("FAIL tput_ready word %0d: got %b want 1", i, b_in_ready[2]);
            end
            step();
            checks++;
            if (b_out_valid !== 1'b1 || b_out_data !== 32'(i)) begin
                fails++;
                $display("FAIL tput_out word %0d: got v=%b d=%h want v=1 d=%h", i, b_out_valid, b_out_data, i);
            end
        end
    endtask

    task automatic test_out_of_range_empty();
        int exp_next;
        // B: Sel beyond NUM_IN never grants; the pending word still drains.
        sel[1] = 3;
        in_valid[1] = 4'b0111;
        out_ready[1] = 1'b0;
        for (int k = 0; k < 3; k++) begin
            if (k > 0) out_ready[1] = 1'b1;
            #1;
            checks++;
            if (b_in_ready !== 3'b000) begin
                fails++;
                $display("FAIL oor_ready step %0d: got %b want 000", k, b_in_ready);
            end
            step();
            checks++;
            if (b_out_valid !== (k == 0)) begin
                fails++;
                $display("FAIL oor_valid step %0d: got %b want %b", k, b_out_valid, k == 0);
            end
        end
        // C: idle cycles must not move the round-robin pointer.
        in_valid[2] = 4'b1111;
        for (int i = 0; i < 4; i++) in_data[2][i] = 32'(i);
        out_ready[2] = 1'b1;
        #1;
        step();
        exp_next = (m_chan[2] + 1) % 4;
        in_valid[2] = 4'b0000;
        repeat (3) begin
            #1;
            checks++;
            if (c_in_ready !== 4'b0000) begin
                fails++;
                $display("FAIL empty_ready: got %b want 0000", c_in_ready);
            end
            step();
        end
        checks++;
        if (c_out_valid !== 1'b0) begin
            fails++;
            $display("FAIL empty_valid: got %b want 0", c_out_valid);
        end
        in_valid[2] = 4'b1111;
        #1;
        checks++;
        if (c_in_ready !== (4'b0001 << exp_next)) begin
            fails++;
            $display("FAIL empty_resume_ready: got %b want %b", c_in_ready, 4'b0001 << exp_next);
        end
        step();
        checks++;
        if (act_chan(2) !== exp_next) begin
            fails++;
            $display("FAIL empty_resume_chan: got %0d want %0d", act_chan(2), exp_next);
        end
    endtask

    task automatic test_round_robin();
        int seq1 [6] = '{0, 1, 2, 3, 0, 1};
        int seq2 [6] = '{2, 3, 0, 2, 3, 0};
        rst_n = 1'b0;
        #1;
        step();
        rst_n = 1'b1;
        in_valid[2] = 4'b1111;
        for (int i = 0; i < 4; i++) in_data[2][i] = 32'(i);
        out_ready[2] = 1'b1;
        for (int k = 0; k < 12; k++) begin
            int want;
            if (k == 6) in_valid[2] = 4'b1101;
            want = (k < 6) ? seq1[k] : seq2[k-6];
            #1;
            step();
            checks++;
            if (c_out_valid !== 1'b1 || act_chan(2) !== want || act_data(2) !== 32'(want)) begin
                fails++;
                $display("FAIL rr_seq grant %0d: got v=%b c=%0d d=%h want v=1 c=%0d d=%h",
                         k, c_out_valid, act_chan(2), act_data(2), want, want);
            end
        end
    endtask

    task automatic test_reset_mid();
        in_valid[2] = 4'b1111;
        out_ready[2] = 1'b0;
        #1;
        step();
        checks++;
        if (c_out_valid !== 1'b1) begin
            fails++;
            $display("FAIL mid_full: got v=%b want 1", c_out_valid);
        end
        rst_n = 1'b0;
        #1;
        checks++;
        if (c_in_ready !== 4'b0000) begin
            fails++;
            $display("FAIL mid_ready_in_reset: got %b want 0000", c_in_ready);
        end
        step();
        checks++;
        if (c_out_valid !== 1'b0 || c_out_data !== 8'd0 || c_out_chan !== 2'd0) begin
            fails++;
            $display("FAIL mid_reset_out: got v=%b d=%h c=%0d want v=0 d=0 c=0",
                     c_out_valid, c_out_data, c_out_chan);
        end
        rst_n = 1'b1;
        out_ready[2] = 1'b1;
        #1;
        checks++;
        if (c_in_ready !== 4'b0001) begin
            fails++;
            $display("FAIL mid_release_ready: got %b want 0001", c_in_ready);
        end
        step();
        checks++;
        if (c_out_valid !== 1'b1 || c_out_chan !== 2'd0 || c_out_data !== 8'd0) begin
            fails++;
            $display("FAIL mid_release_out: got v=%b c=%0d d=%h want v=1 c=0 d=0",
                     c_out_valid, c_out_chan, c_out_data);
        end
    endtask

    task automatic test_random();
        for (int n = 0; n < 400; n++) begin
            rst_n = ($urandom_range(0, 39) != 0);
            for (int d = 0; d < ND; d++) begin
                in_valid[d] = 4'($urandom) & 4'((1 << NIN[d]) - 1);
                sel[d] = (d == 0) ? $urandom_range(0, 1) : $urandom_range(0, 3);
                out_ready[d] = ($urandom_range(0, 3) != 0);
                for (int i = 0; i < 4; i++) in_data[d][i] = $urandom & wmask(d);
            end
            #1;
            for (int d = 0; d < ND; d++) begin
                checks++;
                if (act_ready(d) !== m_ready(d)) begin
                    fails++;
                    $display("FAIL rand_ready dut%0d cyc %0d: got %b want %b", d, n, act_ready(d), m_ready(d));
                end
            end
            step();
            for (int d = 0; d < ND; d++) begin
                checks++;
                if (act_valid(d) !== m_valid[d] || act_data(d) !== m_data[d] || act_chan(d) !== m_chan[d]) begin
                    fails++;
                    $display("FAIL rand_out dut%0d cyc %0d: got v=%b d=%h c=%0d want v=%b d=%h c=%0d",
                             d, n, act_valid(d), act_data(d), act_chan(d), m_valid[d], m_data[d], m_chan[d]);
                end
            end
        end
    endtask

    initial begin
        rst_n = 1'b0;
        for (int d = 0; d < ND; d++) begin
            in_valid[d]  = '0;
            sel[d]       = 0;
            out_ready[d] = 1'b1;
            m_valid[d]   = 1'b0;
            m_data[d]    = '0;
            m_chan[d]    = 0;
            m_last[d]    = NIN[d] - 1;
            for (int i = 0; i < 4; i++) in_data[d][i] = '0;
        end
        test_reset();
        test_legacy_select();
        test_backpressure();
        test_throughput();
        test_out_of_range_empty();
        test_round_robin();
        test_reset_mid();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
